// File: rtl/modrm_fetch_pkg.sv
// Shared ModR/M decode types and helpers: the fetch FSM states and the
// displacement-length rule used by the fetch block, the decoder and length logic.
package modrm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MODRM   = 2'd1,
        DISP_LO = 2'd2,
        DISP_HI = 2'd3
    } modrm_fetch_state_t;

    // Number of displacement bytes that follow a ModR/M byte (16-bit addressing).
    function automatic logic [1:0] modrm_disp_bytes(input logic [7:0] modrm_byte);
        logic [1:0] len;
        case (modrm_byte[7:6])
            2'b00:   len = (modrm_byte[2:0] == 3'b110) ? 2'd2 : 2'd0;
            2'b01:   len = 2'd1;
            2'b10:   len = 2'd2;
            2'b11:   len = 2'd0;
            default: len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/modrm_fetch_if.sv
// Control, byte-stream and result signals between a fetch controller (master)
// and the ModR/M fetch block (slave).
interface modrm_fetch_if;
    logic        start;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        busy;
    logic        complete;
    logic [7:0]  modrm;
    logic [15:0] displacement;
    logic [1:0]  disp_len;

    modport master (
        output start, flush, in_valid, in_data,
        input  in_ready, busy, complete, modrm, displacement, disp_len
    );

    modport slave (
        input  start, flush, in_valid, in_data,
        output in_ready, busy, complete, modrm, displacement, disp_len
    );
endinterface

// File: rtl/modrm_fetch.sv
// Pulls the ModR/M byte plus 0-2 displacement bytes from the instruction byte
// stream and presents the assembled operand fields with a one-cycle complete strobe.
module modrm_fetch
    import modrm_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    modrm_fetch_if.slave bus
);

    modrm_fetch_state_t state_r;
    logic               complete_r;
    logic [7:0]         modrm_r;
    logic [15:0]        displacement_r;
    logic [1:0]         disp_len_r;
    logic [1:0]         len_s;

    assign len_s            = modrm_disp_bytes(bus.in_data);
    assign bus.busy         = (state_r != IDLE);
    assign bus.in_ready     = (state_r != IDLE) && !bus.flush;
    assign bus.complete     = complete_r;
    assign bus.modrm        = modrm_r;
    assign bus.displacement = displacement_r;
    assign bus.disp_len     = disp_len_r;

    // Fetch FSM and operand registers; flush overrides any byte transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            complete_r     <= 1'b0;
            modrm_r        <= 8'h00;
            displacement_r <= 16'h0000;
            disp_len_r     <= 2'd0;
        end else begin
            complete_r <= 1'b0;
            if (bus.flush) begin
                state_r <= IDLE;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (bus.start) begin
                            state_r <= MODRM;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    MODRM: begin
                        if (bus.in_valid) begin
                            modrm_r        <= bus.in_data;
                            displacement_r <= 16'h0000;
                            disp_len_r     <= len_s;
                            if (len_s == 2'd0) begin
                                state_r    <= IDLE;
                                complete_r <= 1'b1;
                            end else begin
                                state_r <= DISP_LO;
                            end
                        end else begin
                            state_r <= MODRM;
                        end
                    end
                    DISP_LO: begin
                        if (bus.in_valid) begin
                            if (disp_len_r == 2'd1) begin
                                displacement_r <= {{8{bus.in_data[7]}}, bus.in_data};
                                state_r        <= IDLE;
                                complete_r     <= 1'b1;
                            end else begin
                                displacement_r[7:0] <= bus.in_data;
                                state_r             <= DISP_HI;
                            end
                        end else begin
                            state_r <= DISP_LO;
                        end
                    end
                    DISP_HI: begin
                        if (bus.in_valid) begin
                            displacement_r[15:8] <= bus.in_data;
                            state_r              <= IDLE;
                            complete_r           <= 1'b1;
                        end else begin
                            state_r <= DISP_HI;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_modrm_fetch.sv
// Directed bench for modrm_fetch: a table of byte streams with hand-computed
// operands, plus hand-written sequences for flush, reset, start and stall corners.
module tb_modrm_fetch;

    logic clk;
    logic reset;
    modrm_fetch_if intf ();

    modrm_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          n;
        int          gap;
        logic [15:0] disp;
        logic [1:0]  len;
    } vec_t;

    vec_t vecs [11];
    int   n_vec;
    int   n_err;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        intf.in_valid = 1'b1;
        intf.in_data  = b;
        #1;
        check("in_ready_on_byte", {31'd0, intf.in_ready}, 32'd1);
        tick();
        intf.in_valid = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic [7:0] m, input logic [15:0] d, input logic [1:0] l);
        check({tag, "_complete"}, {31'd0, intf.complete}, 32'd1);
        check({tag, "_busy"}, {31'd0, intf.busy}, 32'd0);
        check({tag, "_modrm"}, {24'd0, intf.modrm}, {24'd0, m});
        check({tag, "_disp"}, {16'd0, intf.displacement}, {16'd0, d});
        check({tag, "_len"}, {30'd0, intf.disp_len}, {30'd0, l});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset          = 1'b1;
        intf.start     = 1'b0;
        intf.flush     = 1'b0;
        intf.in_valid  = 1'b0;
        intf.in_data   = 8'h00;

        vecs[0]  = '{8'hC3, 8'h00, 8'h00, 1, 0, 16'h0000, 2'd0};
        vecs[1]  = '{8'h46, 8'h80, 8'h00, 2, 0, 16'hFF80, 2'd1};
        vecs[2]  = '{8'h46, 8'h7F, 8'h00, 2, 0, 16'h007F, 2'd1};
        vecs[3]  = '{8'h86, 8'h34, 8'h12, 3, 0, 16'h1234, 2'd2};
        vecs[4]  = '{8'h86, 8'h34, 8'h12, 3, 3, 16'h1234, 2'd2};
        vecs[5]  = '{8'h06, 8'hCD, 8'hAB, 3, 0, 16'hABCD, 2'd2};
        vecs[6]  = '{8'h07, 8'h00, 8'h00, 1, 0, 16'h0000, 2'd0};
        vecs[7]  = '{8'h45, 8'h01, 8'h00, 2, 1, 16'h0001, 2'd1};
        vecs[8]  = '{8'h00, 8'h00, 8'h00, 1, 0, 16'h0000, 2'd0};
        vecs[9]  = '{8'h3E, 8'h11, 8'h22, 3, 2, 16'h2211, 2'd2};
        vecs[10] = '{8'hFE, 8'h00, 8'h00, 1, 0, 16'h0000, 2'd0};

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", {31'd0, intf.busy}, 32'd0);
        check("rst_complete", {31'd0, intf.complete}, 32'd0);
        check("rst_in_ready", {31'd0, intf.in_ready}, 32'd0);
        check("rst_modrm", {24'd0, intf.modrm}, 32'd0);
        check("rst_disp", {16'd0, intf.displacement}, 32'd0);
        check("rst_len", {30'd0, intf.disp_len}, 32'd0);
        tick();

        for (int i = 0; i < 11; i++) begin
            intf.start = 1'b1;
            tick();
            intf.start = 1'b0;
            check("vec_busy_after_start", {31'd0, intf.busy}, 32'd1);
            for (int k = 0; k < vecs[i].n; k++) begin
                if (k > 0) begin
                    for (int g = 0; g < vecs[i].gap; g++) begin
                        tick();
                        check("vec_gap_no_complete", {31'd0, intf.complete}, 32'd0);
                        check("vec_gap_busy", {31'd0, intf.busy}, 32'd1);
                    end
                end
                send_byte(k == 0 ? vecs[i].b0 : (k == 1 ? vecs[i].b1 : vecs[i].b2));
            end
            check_done("vec", vecs[i].b0, vecs[i].disp, vecs[i].len);
            tick();
            check("vec_complete_one_cycle", {31'd0, intf.complete}, 32'd0);
        end

        // 0x07 then 0xAA offered while idle: 0xAA must not be consumed.
        intf.start = 1'b1;
        tick();
        intf.start = 1'b0;
        send_byte(8'h07);
        intf.in_valid = 1'b1;
        intf.in_data  = 8'hAA;
        #1;
        check("idle_in_ready", {31'd0, intf.in_ready}, 32'd0);
        check_done("rm07", 8'h07, 16'h0000, 2'd0);
        tick();
        intf.in_valid = 1'b0;
        check("idle_modrm_kept", {24'd0, intf.modrm}, 32'h07);
        check("idle_no_fetch", {31'd0, intf.busy}, 32'd0);

        // Flush with the last byte valid: no transfer, no complete.
        intf.start = 1'b1;
        tick();
        intf.start = 1'b0;
        send_byte(8'h86);
        send_byte(8'h34);
        intf.in_valid = 1'b1;
        intf.in_data  = 8'h12;
        intf.flush    = 1'b1;
        #1;
        check("flush_in_ready", {31'd0, intf.in_ready}, 32'd0);
        tick();
        intf.flush    = 1'b0;
        intf.in_valid = 1'b0;
        check("flush_no_complete", {31'd0, intf.complete}, 32'd0);
        check("flush_busy", {31'd0, intf.busy}, 32'd0);
        intf.start = 1'b1;
        tick();
        intf.start = 1'b0;
        send_byte(8'hC3);
        check_done("post_flush", 8'hC3, 16'h0000, 2'd0);
        tick();

        // Flush and start together: stays idle.
        intf.start = 1'b1;
        intf.flush = 1'b1;
        tick();
        intf.start = 1'b0;
        intf.flush = 1'b0;
        check("flush_start_busy", {31'd0, intf.busy}, 32'd0);

        // Start while busy is ignored.
        intf.start = 1'b1;
        tick();
        send_byte(8'h46);
        intf.start = 1'b0;
        send_byte(8'h80);
        check_done("start_busy", 8'h46, 16'hFF80, 2'd1);
        tick();
        check("start_busy_no_extra", {31'd0, intf.busy}, 32'd0);

        // Start in the complete cycle: back-to-back, 2 cycles per instruction.
        intf.start = 1'b1;
        tick();
        intf.start = 1'b0;
        send_byte(8'hC3);
        check_done("b2b_first", 8'hC3, 16'h0000, 2'd0);
        intf.start = 1'b1;
        tick();
        intf.start = 1'b0;
        #1;
        check("b2b_busy", {31'd0, intf.busy}, 32'd1);
        check("b2b_in_ready", {31'd0, intf.in_ready}, 32'd1);
        send_byte(8'hC0);
        check_done("b2b_second", 8'hC0, 16'h0000, 2'd0);
        tick();

        // Asynchronous reset while in DISP_HI.
        intf.start = 1'b1;
        tick();
        intf.start = 1'b0;
        send_byte(8'h86);
        send_byte(8'h34);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, intf.busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, intf.in_ready}, 32'd0);
        check("mid_rst_modrm", {24'd0, intf.modrm}, 32'd0);
        check("mid_rst_disp", {16'd0, intf.displacement}, 32'd0);
        check("mid_rst_len", {30'd0, intf.disp_len}, 32'd0);
        check("mid_rst_complete", {31'd0, intf.complete}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_idle", {31'd0, intf.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
